spi_evt_sync_mc: RTL and testbench
==================================

Name: spi_evt_sync_mc

Overview:
- Multi-channel event synchroniser for the SPI/CRG subsystem, running in the receiving domain only.
- Takes NCH asynchronous level inputs (toggles, requests or flags from foreign domains) and passes each through a parametrised-depth synchroniser.
- Per channel it detects a programmable edge type and emits a one-cycle pulse.
- Per channel it also keeps a sticky flag with software clear, a missed-event (overflow) indication and a saturating event counter.

Parameters:
- NCH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- CNT_W, 4, width of each per-channel event counter (>=1).

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- async_in  input  NCH  asynchronous level inputs, one bit per channel.
- edge_mode  input  2*NCH  per channel [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both.
- flag_clr  input  NCH  per-channel clear for evt_flag and evt_ovf.
- cnt_clr  input  NCH  per-channel clear for evt_cnt.
- sync_level  output  NCH  synchronised level (last synchroniser stage).
- evt_pulse  output  NCH  one-cycle event pulse, registered.
- evt_flag  output  NCH  sticky event flag.
- evt_ovf  output  NCH  sticky overflow: event arrived while flag still set.
- evt_cnt  output  NCH*CNT_W  saturating event counters; channel c at [c*CNT_W +: CNT_W].

Behaviour:
- Reset: synchronous; while rst_n=0 at a clk edge, the following all load 0:
  - all synchroniser stages and the edge-history register s_d;
  - evt_pulse, evt_flag, evt_ovf, evt_cnt.
- Reset has priority over every other input, including mid-operation.
- Synchroniser: per channel, chain s[0..S-1] (S = SYNC_STAGES) followed by s_d, which is a register of s[S-1].
  - sync_level = s[S-1].
- Event detect, combinational, per channel:
  - rise = s[S-1] & ~s_d; fall = ~s[S-1] & s_d.
  - evt = (mode[0] & rise) | (mode[1] & fall).
  - Mode 00 masks the channel completely: no pulse, no flag, no overflow, no count.
- edge_mode is sampled combinationally, so a mode change applies to the very next detect cycle.
- Latency: if async_in changes and is first captured by s[0] at edge E0, then:
  - s[S-1] shows the new level after edge E0+S-1;
  - evt_pulse is high for exactly one cycle after edge E0+S.
- Pulse width: evt_pulse is never longer than 1 cycle per transition.
  - Pulses on a channel are separated by at least one low cycle unless mode=11 and the input toggles every cycle. In that case each transition yields one pulse (back-to-back highs are allowed).
- Flag: on an edge with evt=1, evt_flag is set, in the same edge that evt_pulse rises.
  - flag_clr=1 without evt clears evt_flag and evt_ovf.
  - Simultaneous evt and flag_clr: flag stays/becomes 1 (set wins, no event lost); ovf is cleared.
- Overflow: evt=1 with evt_flag already 1 and flag_clr=0 sets evt_ovf. It stays set until flag_clr.
- Counter: evt increments evt_cnt.
  - It saturates at 2^CNT_W-1 and holds; it never wraps.
  - cnt_clr alone loads 0.
  - cnt_clr together with evt loads 1.
- Reset release with async_in already high: s_d=0 after reset, so a rise is detected S+1 edges after the first non-reset edge, if mode rise or both is enabled. This is required behaviour: it reports power-up levels.
- Independence: channels share only clk and rst_n; activity on one channel never affects another.
- Input glitches shorter than one clk period may be missed; no pulse-width guarantee is given below 1 clk period of stable level.

Test Plan:
- Reset / power-up level:
  - Stimulus: S=2; hold rst_n=0 for 3 cycles with async_in=4'b0010, edge_mode all 01, then release.
  - Required response: all outputs 0 during reset; evt_pulse[1] high for one cycle after the 3rd post-reset edge; evt_flag[1]=1; evt_cnt[1]=1; other channels stay 0.
- Latency and edge modes:
  - Stimulus: ch0 mode 01, ch1 10, ch2 11, ch3 00; drive a 0->1->0 pulse of 5 cycles on all channels.
  - Required response: ch0 gives one pulse at E0+2; ch1 gives one pulse at the falling edge +2; ch2 gives two pulses; ch3 gives no pulse, flag or count; sync_level mirrors the input with 2-cycle delay on all channels.
- Flag/overflow priority:
  - Stimulus: ch0 two rise events with no clear in between, then flag_clr.
  - Required response: evt_ovf[0]=1 after the second event; flag_clr clears both flag and ovf.
  - Stimulus: flag_clr asserted in the same cycle as an event.
  - Required response: evt_flag[0]=1, evt_ovf[0]=0.
- Counter saturation/clear:
  - Stimulus: CNT_W=4, mode 11, toggle ch2 20 times.
  - Required response: evt_cnt[2]=15 and holds.
  - Stimulus: cnt_clr coincident with an event.
  - Required response: evt_cnt[2]=1.
  - Stimulus: cnt_clr alone.
  - Required response: evt_cnt[2]=0.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 while an event is in the synchroniser chain.
  - Required response: no pulse emerges; all outputs 0 on the next edge; after release, a constant-0 input produces no event.
- Parameter sweep:
  - Stimulus: NCH=1, SYNC_STAGES=3, CNT_W=1; single rise.
  - Required response: pulse after E0+3; evt_cnt=1 and saturates at 1 on the second event.

Source files
------------

// File: rtl/spi_evt_sync_mc.sv
// Multi-channel event synchroniser: per-channel level sync, programmable edge
// detect, registered pulse, sticky flag/overflow and saturating event counter.
module spi_evt_sync_mc #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       async_in,
  input  logic [2*NCH-1:0]     edge_mode,
  input  logic [NCH-1:0]       flag_clr,
  input  logic [NCH-1:0]       cnt_clr,
  output logic [NCH-1:0]       sync_level,
  output logic [NCH-1:0]       evt_pulse,
  output logic [NCH-1:0]       evt_flag,
  output logic [NCH-1:0]       evt_ovf,
  output logic [NCH*CNT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]       sync_q [SYNC_STAGES];
  logic [NCH-1:0]       hist_q;
  logic [NCH-1:0]       pulse_q, flag_q, ovf_q;
  logic [NCH*CNT_W-1:0] cnt_q;

  logic [NCH-1:0]       rise, fall, evt;
  logic [NCH-1:0]       flag_d, ovf_d;
  logic [NCH*CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0]     cur_cnt;

  always_comb begin
    rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall    = ~sync_q[SYNC_STAGES-1] & hist_q;
    evt     = '0;
    cnt_d   = cnt_q;
    cur_cnt = '0;
    for (int c = 0; c < NCH; c++) begin
      evt[c] = (edge_mode[2*c] & rise[c]) | (edge_mode[2*c+1] & fall[c]);
    end
    // Set beats clear on the flag so no event is lost; clear always wins on ovf.
    flag_d = evt | (flag_q & ~flag_clr);
    ovf_d  = ~flag_clr & (ovf_q | (evt & flag_q));
    for (int c = 0; c < NCH; c++) begin
      cur_cnt = cnt_q[c*CNT_W +: CNT_W];
      if (cnt_clr[c]) begin
        cnt_d[c*CNT_W +: CNT_W] = evt[c] ? CNT_W'(1) : '0;
      end else if (evt[c] && (cur_cnt != CNT_MAX)) begin
        cnt_d[c*CNT_W +: CNT_W] = cur_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q  <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= evt;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign evt_pulse  = pulse_q;
  assign evt_flag   = flag_q;
  assign evt_ovf    = ovf_q;
  assign evt_cnt    = cnt_q;

endmodule

// File: tb/tb_spi_evt_sync_mc.sv
// Scoreboard bench: a queue-based reference model predicts every output each
// cycle for a default instance and a NCH=1/SYNC_STAGES=3/CNT_W=1 instance.
module tb_spi_evt_sync_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  ain, fclr, cclr;
  logic [7:0]  mode;
  logic [3:0]  lvl, pul, flg, ovf;
  logic [15:0] cnt;

  logic       a2, f2, c2;
  logic [1:0] m2;
  logic       l2, p2, fl2, o2, cn2;

  spi_evt_sync_mc #(.NCH(4), .SYNC_STAGES(2), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .async_in(ain), .edge_mode(mode),
    .flag_clr(fclr), .cnt_clr(cclr), .sync_level(lvl), .evt_pulse(pul),
    .evt_flag(flg), .evt_ovf(ovf), .evt_cnt(cnt));

  spi_evt_sync_mc #(.NCH(1), .SYNC_STAGES(3), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .async_in(a2), .edge_mode(m2),
    .flag_clr(f2), .cnt_clr(c2), .sync_level(l2), .evt_pulse(p2),
    .evt_flag(fl2), .evt_ovf(o2), .evt_cnt(cn2));

  typedef struct {
    logic [3:0]  lvl, pul, flg, ovf;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq0[$], sbq1[$];
  exp_t e0, e1, m0, m1;

  // Model: mh[k][0] is the most recently captured input; the synchronised
  // level is the capture SYNC_STAGES-1 edges old, and one older is history.
  logic [3:0] mh [2][0:3];
  logic [3:0] m_flg [2];
  logic [3:0] m_ovf [2];
  int         m_cnt [2][4];

  int tests = 0;
  int fails = 0;

  task automatic model_step(input int k, input int st, input int nch, input int cw,
                            input logic rst, input logic [3:0] a, input logic [7:0] md,
                            input logic [3:0] fc, input logic [3:0] cc, output exp_t e);
    logic [3:0] p;
    logic cur, prv, ev;
    int cmax;
    p = '0;
    cmax = (1 << cw) - 1;
    if (!rst) begin
      for (int i = 0; i <= 3; i++) mh[k][i] = '0;
      m_flg[k] = '0;
      m_ovf[k] = '0;
      for (int c = 0; c < 4; c++) m_cnt[k][c] = 0;
    end else begin
      for (int c = 0; c < nch; c++) begin
        cur = mh[k][st-1][c];
        prv = mh[k][st][c];
        ev  = (md[2*c] && cur && !prv) || (md[2*c+1] && !cur && prv);
        if (fc[c]) m_ovf[k][c] = 1'b0;
        else if (ev && m_flg[k][c]) m_ovf[k][c] = 1'b1;
        if (ev) m_flg[k][c] = 1'b1;
        else if (fc[c]) m_flg[k][c] = 1'b0;
        if (cc[c]) m_cnt[k][c] = ev ? 1 : 0;
        else if (ev && m_cnt[k][c] < cmax) m_cnt[k][c]++;
        p[c] = ev;
      end
      for (int i = 3; i >= 1; i--) mh[k][i] = mh[k][i-1];
      mh[k][0] = a;
    end
    e.lvl = mh[k][st-1];
    e.pul = p;
    e.flg = m_flg[k];
    e.ovf = m_ovf[k];
    e.cnt = '0;
    for (int c = 0; c < nch; c++) e.cnt |= 16'(m_cnt[k][c]) << (c*cw);
  endtask

  always @(posedge clk) begin
    model_step(0, 2, 4, 4, rst_n, ain, mode, fclr, cclr, e0);
    sbq0.push_back(e0);
    model_step(1, 3, 1, 1, rst_n, {3'b000, a2}, {6'b0, m2}, {3'b000, f2}, {3'b000, c2}, e1);
    sbq1.push_back(e1);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq0.size() > 0) begin
      m0 = sbq0.pop_front();
      chk("lvl0", {12'b0, lvl}, {12'b0, m0.lvl});
      chk("pulse0", {12'b0, pul}, {12'b0, m0.pul});
      chk("flag0", {12'b0, flg}, {12'b0, m0.flg});
      chk("ovf0", {12'b0, ovf}, {12'b0, m0.ovf});
      chk("cnt0", cnt, m0.cnt);
    end
    if (sbq1.size() > 0) begin
      m1 = sbq1.pop_front();
      chk("lvl1", {15'b0, l2}, {15'b0, m1.lvl[0]});
      chk("pulse1", {15'b0, p2}, {15'b0, m1.pul[0]});
      chk("flag1", {15'b0, fl2}, {15'b0, m1.flg[0]});
      chk("ovf1", {15'b0, o2}, {15'b0, m1.ovf[0]});
      chk("cnt1", {15'b0, cn2}, {15'b0, m1.cnt[0]});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ain = 4'b0010; mode = 8'h55; fclr = '0; cclr = '0;
    a2 = 1'b0; m2 = 2'b11; f2 = 1'b0; c2 = 1'b0;
    cyc(3);
    rst_n = 1'b1; a2 = 1'b1;
    cyc(6);
    chk("pwrup_flag", {12'b0, flg}, 16'h0002);
    chk("pwrup_cnt", cnt, 16'h0010);

    // Edge modes: ch0 rise, ch1 fall, ch2 both, ch3 off
    ain = '0; a2 = 1'b0;
    cyc(4);
    mode = 8'h39;
    ain = 4'hF; cyc(5);
    ain = 4'h0; cyc(6);

    // Flag / overflow
    mode = 8'h01; m2 = 2'b01;
    fclr = 4'hF; cyc(); fclr = '0;
    ain[0] = 1'b1; a2 = 1'b1; cyc(2); ain[0] = 1'b0; a2 = 1'b0; cyc(2);
    ain[0] = 1'b1; a2 = 1'b1; cyc(2); ain[0] = 1'b0; a2 = 1'b0; cyc(4);
    fclr = 4'h1; cyc(); fclr = '0; cyc();
    ain[0] = 1'b1; cyc(2);
    fclr = 4'h1; cyc(); fclr = '0;
    ain[0] = 1'b0; cyc(3);
    chk("clr_evt_flag", {15'b0, flg[0]}, 16'h0001);
    chk("clr_evt_ovf", {15'b0, ovf[0]}, 16'h0000);

    // Counter saturation and clear on ch2
    mode = 8'h30;
    for (int i = 0; i < 20; i++) begin
      ain[2] = ~ain[2]; cyc(2);
    end
    cyc(4);
    chk("cnt_sat", {12'b0, cnt[11:8]}, 16'h000F);
    ain[2] = ~ain[2]; cyc(2);
    cclr = 4'h4; cyc(); cclr = '0;
    cyc(4);
    chk("cnt_clr_evt", {12'b0, cnt[11:8]}, 16'h0001);
    cclr = 4'h4; cyc(); cclr = '0;
    cyc(2);
    chk("cnt_clr", {12'b0, cnt[11:8]}, 16'h0000);

    // Mid-operation reset with an event in flight
    mode = 8'hFF; m2 = 2'b11;
    ain = '0; cyc(4);
    ain = 4'h1; a2 = 1'b1; cyc();
    rst_n = 1'b0; ain = '0; a2 = 1'b0; cyc();
    rst_n = 1'b1; cyc(6);

    // Randomised phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) ain = ain ^ 4'($urandom);
      if ($urandom_range(0, 2) == 0) a2 = 1'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 15) == 0) m2 = 2'($urandom);
      fclr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      cclr = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
      f2   = ($urandom_range(0, 7) == 0);
      c2   = ($urandom_range(0, 11) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      cyc();
    end
    rst_n = 1'b1; fclr = '0; cclr = '0; f2 = 1'b0; c2 = 1'b0;
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
